// File: rtl/mul_seq_unit.sv
// Sequential shift-add multiplier for MUL/MLA: one conditional add per cycle,
// low WIDTH bits of A*B (+C) with N/Z flags, optional early exit on exhausted multiplier.
module mul_seq_unit #(
  parameter int WIDTH      = 32,
  parameter bit EARLY_TERM = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Start,
  input  logic             Abort,
  input  logic             Accumulate,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] C,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Result,
  output logic             N,
  output logic             Z
);

  localparam int SW = $clog2(WIDTH);
  localparam logic [SW-1:0] LAST_STEP = SW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [SW-1:0]    step;

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] acc_nxt;
  logic             last;

  // Plain modular add; this is the operand pair handed to the downstream CLA (sel=0, Cin=0).
  assign sum     = acc + mcand;
  assign acc_nxt = mplier[0] ? sum : acc;

  // Early exit once no set multiplier bits remain after this step; the step
  // counter covers the full-length case.
  assign last = EARLY_TERM ? (mplier[WIDTH-1:1] == '0) : (step == LAST_STEP);

  assign Busy = (state == S_MUL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      step   <= '0;
      Done   <= 1'b0;
      Result <= '0;
      N      <= 1'b0;
      Z      <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (Start && !Abort) begin
            mcand  <= A;
            mplier <= B;
            acc    <= Accumulate ? C : '0;
            step   <= '0;
            state  <= S_MUL;
          end
        end
        S_MUL: begin
          if (Abort) begin
            state <= S_IDLE;
          end else begin
            acc    <= acc_nxt;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            step   <= step + 1'b1;
            if (last) begin
              Result <= acc_nxt;
              N      <= acc_nxt[WIDTH-1];
              Z      <= (acc_nxt == '0);
              Done   <= 1'b1;
              state  <= S_DONE;
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_seq_unit.sv
// Directed bench for mul_seq_unit: one instance with early exit, one running full length.
module tb_mul_seq_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start0 = 1'b0, start1 = 1'b0, abort = 1'b0, mla = 1'b0;
  logic [31:0] a = '0, b = '0, c = '0;
  logic        busy0, done0, n0, z0, busy1, done1, n1, z1;
  logic [31:0] res0, res1;
  int          checks = 0;
  int          fails  = 0;

  always #5 clk = ~clk;

  mul_seq_unit #(.WIDTH(32), .EARLY_TERM(1'b1)) dut0 (
    .clk(clk), .rst(rst), .Start(start0), .Abort(abort), .Accumulate(mla),
    .A(a), .B(b), .C(c), .Busy(busy0), .Done(done0), .Result(res0), .N(n0), .Z(z0)
  );

  mul_seq_unit #(.WIDTH(32), .EARLY_TERM(1'b0)) dut1 (
    .clk(clk), .rst(rst), .Start(start1), .Abort(abort), .Accumulate(mla),
    .A(a), .B(b), .C(c), .Busy(busy1), .Done(done1), .Result(res1), .N(n1), .Z(z1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Leaves the bench at the falling edge right after the accepting edge.
  task automatic launch(input logic [31:0] ia, ib, ic, input logic im, input int w);
    @(negedge clk);
    a = ia; b = ib; c = ic; mla = im;
    if (w == 0) start0 = 1'b1; else start1 = 1'b1;
    @(negedge clk);
    start0 = 1'b0; start1 = 1'b0;
  endtask

  task automatic wait_done(input int w, output int cyc, output int bc);
    cyc = 0; bc = 0;
    while (cyc < 40) begin
      if (w == 0 ? busy0 : busy1) bc++;
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (w == 0 ? done0 : done1) break;
    end
  endtask

  task automatic run(input string tag, input logic [31:0] ia, ib, ic, input logic im,
                     input int w, input int exp_k, input logic [31:0] exp_res);
    int cyc, bc;
    launch(ia, ib, ic, im, w);
    wait_done(w, cyc, bc);
    chk({tag, ".lat"}, cyc, exp_k);
    chk({tag, ".busy"}, bc, exp_k);
    chk({tag, ".res"}, w == 0 ? res0 : res1, exp_res);
    chk({tag, ".n"}, w == 0 ? n0 : n1, {31'd0, exp_res[31]});
    chk({tag, ".z"}, w == 0 ? z0 : z1, {31'd0, exp_res == 32'd0});
  endtask

  initial begin
    int  cyc, bc;
    bit  saw;
    #1 rst = 1'b1;
    #11;
    chk("rst.busy", busy0, 0);
    chk("rst.done", done0, 0);
    chk("rst.res", res0, 0);
    chk("rst.nz", {n0, z0}, 0);
    chk("rst.res1", res1, 0);
    @(negedge clk) rst = 1'b0;

    run("t1", 32'd7, 32'd6, 32'd0, 1'b0, 0, 3, 32'd42);
    run("t2", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 1'b1, 0, 32, 32'd2);
    run("t3a", 32'h0001_0000, 32'h0001_0000, 32'd0, 1'b0, 0, 17, 32'd0);
    run("t3b", 32'h8000_0000, 32'd1, 32'd0, 1'b0, 0, 1, 32'h8000_0000);
    run("t4a", 32'd5, 32'd0, 32'h1234, 1'b1, 0, 1, 32'h1234);
    run("t4b", 32'd5, 32'd0, 32'h1234, 1'b1, 1, 32, 32'h1234);
    run("et0", 32'd7, 32'd6, 32'd0, 1'b0, 1, 32, 32'd42);

    // Start together with Abort in IDLE is refused
    @(negedge clk); start0 = 1'b1; abort = 1'b1;
    @(negedge clk); start0 = 1'b0; abort = 1'b0;
    chk("sa.busy", busy0, 0);
    @(negedge clk);
    chk("sa.done", done0, 0);

    // Abort during step 5 of a 16-step operation
    launch(32'd3, 32'h0000_FFFF, 32'd0, 1'b0, 0);
    repeat (4) @(negedge clk);
    chk("ab.busy_pre", busy0, 1);
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    chk("ab.busy", busy0, 0);
    chk("ab.done", done0, 0);
    chk("ab.res", res0, 32'h1234);
    saw = 1'b0;
    repeat (20) begin @(negedge clk); if (done0) saw = 1'b1; end
    chk("ab.nodone", saw, 0);
    run("ab.next", 32'd5, 32'd5, 32'd0, 1'b0, 0, 3, 32'd25);

    // Second Start while busy must not touch the operands
    launch(32'd2, 32'h0000_0100, 32'd0, 1'b0, 0);
    start0 = 1'b1; a = 32'd9; b = 32'd9;
    @(negedge clk); start0 = 1'b0;
    wait_done(0, cyc, bc);
    chk("sb.lat", cyc, 8);
    chk("sb.res", res0, 32'h200);

    // Asynchronous reset mid-operation
    launch(32'd3, 32'h0000_FFFF, 32'd0, 1'b0, 0);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mr.busy", busy0, 0);
    chk("mr.res", res0, 0);
    chk("mr.done", done0, 0);
    @(negedge clk) rst = 1'b0;
    saw = 1'b0;
    repeat (40) begin @(negedge clk); if (done0 || busy0) saw = 1'b1; end
    chk("mr.quiet", saw, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
